ripple_count_extender: RTL and testbench
========================================

Name: ripple_count_extender

Overview:
- Downstream stage for the 2-bit asynchronous up counter.
- Samples the counter's raw ripple output into the system clock domain and filters out settling glitches.
- Extends the count with a wide synchronous high-order register that increments on every detected wrap.
- Delivers captured extended-count snapshots over a valid/ready handshake, and flags wraps and overflow.

Parameters:
- CNT_W, 2, width of the ripple counter value being monitored.
- EXT_W, 8, width of the synchronous high-order extension register.
- STABLE_N, 2, consecutive identical synchronized samples required before a value is accepted (legal range 1..15).

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cnt_in  input  CNT_W  raw ripple counter output; asynchronous to clk and may glitch.
- clear  input  1  synchronous clear of the extension and overflow.
- capture_req  input  1  single-cycle request to snapshot the extended count.
- ext_ready  input  1  consumer accepts the snapshot.
- ext_count  output  CNT_W+EXT_W  snapshot value {hi, filt}.
- ext_valid  output  1  snapshot is valid.
- capture_busy  output  1  high while a snapshot is pending.
- wrap_pulse  output  1  one-cycle pulse on each detected low-count wrap.
- overflow  output  1  sticky flag; the hi register wrapped.

Behaviour:
- Reset (asynchronous, rst=1):
  - s1, s2, s3, filt, hi, run counter, ext_count: 0.
  - ext_valid, capture_busy, wrap_pulse, overflow: 0.
  - FSM state: IDLE.
- Synchronizer: two flops, s1 <= cnt_in and s2 <= s1. No logic between them.
- Stability filter:
  - s3 <= s2.
  - run counter: reset to 0 when s2 != s3; otherwise increments, saturating at STABLE_N-1.
  - When run == STABLE_N-1, s2 == s3 and s2 != filt: filt <= s2 and prev <= filt.
  - Latency: filt reflects a settled cnt_in 2+STABLE_N clk edges after it settles (4 edges at the default).
- Wrap detection, evaluated on a filt update:
  - If new filt < old filt (unsigned), a wrap is detected: hi <= hi+1 and wrap_pulse=1 for exactly one cycle.
  - If hi == all-ones at a wrap, hi goes to 0 and overflow is set, sticky.
  - A multi-step jump (e.g. 0→2) is accepted without error. Correctness requires fewer than 2^CNT_W counter steps between accepted samples. This is a system constraint and is not checked.
- clear:
  - Next edge: hi <= 0, overflow <= 0. filt, the synchronizer and the FSM are unaffected.
  - Clear coinciding with a wrap: clear wins. hi=0 and wrap_pulse is suppressed.
- Capture FSM, states IDLE, SNAP, HOLD:
  - IDLE: capture_req=1 → SNAP.
  - SNAP (1 cycle): ext_count <= {hi, filt} using the register values at this edge, ext_valid <= 1 → HOLD. A wrap update in the same cycle is not included in the snapshot.
  - HOLD: ext_valid=1 and ext_count stays stable until ext_valid & ext_ready. On that edge: ext_valid <= 0 → IDLE.
  - capture_busy=1 in SNAP and HOLD.
  - capture_req outside IDLE is ignored and is not queued.
  - ext_ready while ext_valid=0 has no effect.
- Reset mid-handshake: immediate return to IDLE with ext_valid=0. Any pending snapshot is lost.
- All outputs are registered.

Decomposition:
- Shared counter package holds:
  - default widths (CNT_W, EXT_W);
  - the FSM state encoding (IDLE=2'b00, SNAP=2'b01, HOLD=2'b10);
  - a function for unsigned wrap compare.
- One sub-module is natural: sync_stable_filter, covering the two-flop synchronizer, s3 and the run counter. It is parameterized by CNT_W and STABLE_N, and outputs filt plus a one-cycle filt_upd strobe.

Test Plan:
- Reset: assert rst mid-cycle with cnt_in=3 → all outputs 0 immediately. After release with cnt_in held at 0, filt stays 0 and wrap_pulse never fires.
- Count sequence: drive cnt_in 0,1,2,3,0, each held 10 cycles → filt follows with 4-edge latency. Exactly one wrap_pulse appears, aligned with the 3→0 update, and hi=1.
- Glitch rejection: cnt_in 1→3 for 1 cycle→2 (the ripple transient) → filt goes 1→2 and never takes 3. No wrap_pulse.
- Overflow and clear:
  - Run 256 full wraps with EXT_W=8 → hi=0, overflow=1 after the 256th wrap.
  - Assert clear on the cycle of a wrap update → hi=0, overflow=0, and no wrap_pulse that cycle.
- Handshake:
  - With hi=5 and filt=2, pulse capture_req → ext_valid rises 2 edges later with ext_count=10'h016.
  - Hold ext_ready=0 for 5 cycles while cnt_in keeps counting → ext_count stays stable.
  - A second capture_req in HOLD is ignored.
  - ext_ready=1 → ext_valid drops next edge and the FSM returns to IDLE.
- Reset in HOLD: assert rst while ext_valid=1 → ext_valid=0 and capture_busy=0 immediately. A new capture after release returns the current {hi, filt}.

Source files
------------

// File: rtl/ripple_count_extender_pkg.sv
// Shared definitions for the ripple counter extension slice: default widths,
// capture FSM encoding and the unsigned wrap compare.
package ripple_count_extender_pkg;

    localparam int CNT_W_DEF = 2;
    localparam int EXT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SNAP = 2'b01,
        HOLD = 2'b10
    } cap_state_t;

    // A move to a smaller low count means the ripple counter passed through zero.
    // Arguments are zero-extended to 16 bits so any CNT_W up to 16 can use this.
    function automatic logic is_wrap(input logic [15:0] new_val, input logic [15:0] old_val);
        return new_val < old_val;
    endfunction

endpackage

// File: rtl/ripple_count_extender_sync_stable_filter.sv
// Brings the raw ripple counter value into the clk domain and only accepts a
// value once it has been seen STABLE_N consecutive times after synchronization.
module sync_stable_filter #(
    parameter int CNT_W    = 2,
    parameter int STABLE_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] filt,
    output logic [CNT_W-1:0] prev,
    output logic             filt_upd
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_N - 1);

    logic [CNT_W-1:0] s1;
    logic [CNT_W-1:0] s2;
    logic [CNT_W-1:0] s3;
    logic [3:0]       run;
    logic [3:0]       run_next;
    logic             accept;

    // Run length of identical synchronized samples, saturating at RUN_MAX.
    always_comb begin
        // NOTE: default first so every path assigns run_next and no latch is inferred.
        run_next = run;
        if (s2 != s3) begin
            run_next = '0;
        end else if (run != RUN_MAX) begin
            run_next = run + 4'd1;
        end
    end

    // s2 has matched its last STABLE_N-1 predecessors and differs from the held value.
    assign accept = (run_next == RUN_MAX) && (s2 != filt);

    // Two-flop synchronizer with nothing between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            // NOTE: non-blocking so s2 takes the old s1, forming a real two-stage chain.
            s1 <= cnt_in;
            s2 <= s1;
        end
    end

    // Stability tracking and acceptance of a settled value into filt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3       <= '0;
            run      <= '0;
            filt     <= '0;
            prev     <= '0;
            filt_upd <= 1'b0;
        end else begin
            s3       <= s2;
            run      <= run_next;
            filt_upd <= accept;
            if (accept) begin
                filt <= s2;
                prev <= filt;
            end
        end
    end

endmodule

// File: rtl/ripple_count_extender.sv
// Extends a 2-bit asynchronous ripple counter with a synchronous high-order
// register and hands out {hi, filt} snapshots over a valid/ready handshake.
module ripple_count_extender
    import ripple_count_extender_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int EXT_W    = EXT_W_DEF,
    parameter int STABLE_N = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT_W-1:0]       cnt_in,
    input  logic                   clear,
    input  logic                   capture_req,
    input  logic                   ext_ready,
    output logic [CNT_W+EXT_W-1:0] ext_count,
    output logic                   ext_valid,
    output logic                   capture_busy,
    output logic                   wrap_pulse,
    output logic                   overflow
);

    logic [CNT_W-1:0] filt;
    logic [CNT_W-1:0] prev;
    logic             filt_upd;
    logic [EXT_W-1:0] hi;
    logic             wrap_det;
    cap_state_t       state;

    sync_stable_filter #(
        .CNT_W    (CNT_W),
        .STABLE_N (STABLE_N)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .filt     (filt),
        .prev     (prev),
        .filt_upd (filt_upd)
    );

    assign wrap_det = filt_upd && is_wrap(16'(filt), 16'(prev));

    // High-order extension: bump on each wrap, clear has priority over a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi         <= '0;
            overflow   <= 1'b0;
            wrap_pulse <= 1'b0;
        end else if (clear) begin
            hi         <= '0;
            overflow   <= 1'b0;
            wrap_pulse <= 1'b0;
        end else if (wrap_det) begin
            hi         <= hi + EXT_W'(1);
            wrap_pulse <= 1'b1;
            if (&hi) begin
                overflow <= 1'b1;
            end
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

    // Capture FSM: snapshot {hi, filt} once and hold it until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ext_count    <= '0;
            ext_valid    <= 1'b0;
            capture_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture_req) begin
                        state        <= SNAP;
                        capture_busy <= 1'b1;
                    end
                end
                SNAP: begin
                    ext_count    <= {hi, filt};
                    ext_valid    <= 1'b1;
                    capture_busy <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (ext_valid && ext_ready) begin
                        ext_valid    <= 1'b0;
                        capture_busy <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    ext_valid    <= 1'b0;
                    capture_busy <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_count_extender.sv
// Self-checking bench for ripple_count_extender: directed scenarios plus a
// randomized run, all compared against a sample-history reference model.
module tb_ripple_count_extender;

    localparam int CNT_W    = 2;
    localparam int EXT_W    = 8;
    localparam int STABLE_N = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CNT_W-1:0]       cnt_in;
    logic                   clear;
    logic                   capture_req;
    logic                   ext_ready;
    logic [CNT_W+EXT_W-1:0] ext_count;
    logic                   ext_valid;
    logic                   capture_busy;
    logic                   wrap_pulse;
    logic                   overflow;

    int vectors     = 0;
    int miscompares = 0;

    ripple_count_extender #(
        .CNT_W    (CNT_W),
        .EXT_W    (EXT_W),
        .STABLE_N (STABLE_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cnt_in       (cnt_in),
        .clear        (clear),
        .capture_req  (capture_req),
        .ext_ready    (ext_ready),
        .ext_count    (ext_count),
        .ext_valid    (ext_valid),
        .capture_busy (capture_busy),
        .wrap_pulse   (wrap_pulse),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a value is accepted once the input, seen two edges late,
    // has been identical for STABLE_N edges; wraps land one edge after acceptance.
    logic [CNT_W-1:0]       smp[$];
    logic [CNT_W-1:0]       m_filt;
    logic [EXT_W-1:0]       m_hi;
    logic                   m_ovf, m_wp, m_valid, m_busy, m_wrap_due;
    logic [CNT_W+EXT_W-1:0] m_cnt;
    int                     m_phase; // 0 idle, 1 snapshot pending, 2 holding

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            smp = {};
            for (int i = 0; i < 20; i++) smp.push_front('0);
            m_filt = '0; m_hi = '0; m_ovf = 0; m_wp = 0;
            m_valid = 0; m_busy = 0; m_wrap_due = 0; m_cnt = '0; m_phase = 0;
        end else begin
            logic [CNT_W-1:0] cand;
            logic             stable;
            case (m_phase)
                0: if (capture_req) m_phase = 1;
                1: begin m_cnt = {m_hi, m_filt}; m_valid = 1; m_phase = 2; end
                default: if (ext_ready) begin m_valid = 0; m_phase = 0; end
            endcase
            m_busy = (m_phase != 0);
            if (clear) begin
                m_hi = '0; m_ovf = 0; m_wp = 0;
            end else if (m_wrap_due) begin
                m_wp = 1;
                if (m_hi == '1) m_ovf = 1;
                m_hi = m_hi + 1'b1;
            end else begin
                m_wp = 0;
            end
            smp.push_front(cnt_in);
            void'(smp.pop_back());
            cand   = smp[2];
            stable = 1;
            for (int j = 3; j <= 1 + STABLE_N; j++) if (smp[j] != cand) stable = 0;
            m_wrap_due = 0;
            if (stable && cand != m_filt) begin
                m_wrap_due = (cand < m_filt);
                m_filt     = cand;
            end
        end
    end

    wire [15:0] act_bus = {ext_count, ext_valid, capture_busy, wrap_pulse, overflow, dut.filt};
    wire [15:0] exp_bus = {m_cnt, m_valid, m_busy, m_wp, m_ovf, m_filt};

    task automatic test_reset();
        vectors++;
        if (act_bus !== 16'h0) begin
            miscompares++; $display("FAIL reset_state: got %h expected 0000", act_bus);
        end
        cnt_in = 2'd3;
        repeat (10) @(negedge clk);
        vectors++;
        if (dut.filt !== 2'd3) begin
            miscompares++; $display("FAIL pre_reset_filt: got %0d expected 3", dut.filt);
        end
        @(posedge clk); #2 rst = 1'b1; #1;
        vectors++;
        if (act_bus !== 16'h0) begin
            miscompares++; $display("FAIL reset_async: got %h expected 0000", act_bus);
        end
        cnt_in = 2'd0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (wrap_pulse !== 1'b0 || dut.filt !== 2'd0) begin
                miscompares++; $display("FAIL post_reset_quiet: wrap=%b filt=%0d expected 0/0", wrap_pulse, dut.filt);
            end
        end
    endtask

    task automatic test_count();
        logic [1:0] seq [5];
        logic [1:0] last;
        int         pulses = 0;
        seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        last = 2'd0;
        for (int k = 0; k < 5; k++) begin
            cnt_in = seq[k];
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (wrap_pulse === 1'b1) pulses++;
                vectors++;
                if (act_bus !== exp_bus) begin
                    miscompares++; $display("FAIL count_model: got %h expected %h", act_bus, exp_bus);
                end
                if (i == 3 && seq[k] != last) begin
                    vectors++;
                    if (dut.filt !== last) begin
                        miscompares++; $display("FAIL count_early: got %0d expected %0d", dut.filt, last);
                    end
                end
                if (i == 4) begin
                    vectors++;
                    if (dut.filt !== seq[k]) begin
                        miscompares++; $display("FAIL count_latency: got %0d expected %0d", dut.filt, seq[k]);
                    end
                end
                if (k == 4 && i == 5) begin
                    vectors++;
                    if (wrap_pulse !== 1'b1) begin
                        miscompares++; $display("FAIL count_wrap_align: got %b expected 1", wrap_pulse);
                    end
                end
            end
            last = seq[k];
        end
        vectors++;
        if (pulses != 1 || dut.hi !== 8'd1) begin
            miscompares++; $display("FAIL count_wraps: pulses=%0d hi=%0d expected 1/1", pulses, dut.hi);
        end
    endtask

    task automatic test_glitch();
        logic [1:0] pat [3];
        int         len [3];
        pat = '{2'd1, 2'd3, 2'd2};
        len = '{10, 1, 10};
        for (int k = 0; k < 3; k++) begin
            cnt_in = pat[k];
            for (int i = 0; i < len[k]; i++) begin
                @(negedge clk);
                vectors++;
                if (dut.filt === 2'd3 || wrap_pulse !== 1'b0 || act_bus !== exp_bus) begin
                    miscompares++; $display("FAIL glitch: got %h expected %h (filt must avoid 3)", act_bus, exp_bus);
                end
            end
        end
        vectors++;
        if (dut.filt !== 2'd2 || dut.hi !== 8'd1) begin
            miscompares++; $display("FAIL glitch_final: filt=%0d hi=%0d expected 2/1", dut.filt, dut.hi);
        end
    endtask

    task automatic test_overflow();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        for (int w = 1; w <= 256; w++) begin
            cnt_in = 2'd2; repeat (6) @(negedge clk);
            cnt_in = 2'd0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                vectors++;
                if (act_bus !== exp_bus) begin
                    miscompares++; $display("FAIL overflow_model w%0d: got %h expected %h", w, act_bus, exp_bus);
                end
            end
            if (w == 255) begin
                vectors++;
                if (overflow !== 1'b0 || dut.hi !== 8'hFF) begin
                    miscompares++; $display("FAIL overflow_255: ovf=%b hi=%0d expected 0/255", overflow, dut.hi);
                end
            end
        end
        vectors++;
        if (overflow !== 1'b1 || dut.hi !== 8'h00) begin
            miscompares++; $display("FAIL overflow_256: ovf=%b hi=%0d expected 1/0", overflow, dut.hi);
        end
    endtask

    task automatic test_clear_on_wrap();
        bit found = 0;
        cnt_in = 2'd2; repeat (6) @(negedge clk);
        cnt_in = 2'd0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (m_wrap_due) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL clear_wrap_timeout: got no wrap within 10 cycles expected one");
        end
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        vectors++;
        if (wrap_pulse !== 1'b0 || overflow !== 1'b0 || dut.hi !== 8'd0 || act_bus !== exp_bus) begin
            miscompares++; $display("FAIL clear_wrap: wrap=%b ovf=%b hi=%0d expected 0/0/0", wrap_pulse, overflow, dut.hi);
        end
    endtask

    task automatic test_handshake();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        for (int w = 0; w < 5; w++) begin
            cnt_in = 2'd2; repeat (6) @(negedge clk);
            cnt_in = 2'd0; repeat (6) @(negedge clk);
        end
        cnt_in = 2'd2; repeat (6) @(negedge clk);
        capture_req = 1'b1; @(negedge clk); capture_req = 1'b0;
        vectors++;
        if (ext_valid !== 1'b0 || capture_busy !== 1'b1) begin
            miscompares++; $display("FAIL hs_snap: valid=%b busy=%b expected 0/1", ext_valid, capture_busy);
        end
        @(negedge clk);
        vectors++;
        if (ext_valid !== 1'b1 || ext_count !== 10'h016) begin
            miscompares++; $display("FAIL hs_value: valid=%b count=%h expected 1/016", ext_valid, ext_count);
        end
        ext_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cnt_in      = (i < 2) ? 2'd3 : 2'd0;
            capture_req = (i == 1);
            @(negedge clk);
            vectors++;
            if (ext_valid !== 1'b1 || ext_count !== 10'h016 || act_bus !== exp_bus) begin
                miscompares++; $display("FAIL hs_hold: valid=%b count=%h expected 1/016", ext_valid, ext_count);
            end
        end
        capture_req = 1'b0;
        ext_ready = 1'b1; @(negedge clk); ext_ready = 1'b0;
        vectors++;
        if (ext_valid !== 1'b0 || capture_busy !== 1'b0) begin
            miscompares++; $display("FAIL hs_accept: valid=%b busy=%b expected 0/0", ext_valid, capture_busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (ext_valid !== 1'b0 || capture_busy !== 1'b0) begin
                miscompares++; $display("FAIL hs_no_queue: valid=%b busy=%b expected 0/0", ext_valid, capture_busy);
            end
        end
    endtask

    task automatic test_reset_in_hold();
        cnt_in = 2'd1; repeat (6) @(negedge clk);
        capture_req = 1'b1; @(negedge clk); capture_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (ext_valid !== 1'b1) begin
            miscompares++; $display("FAIL rh_valid: got %b expected 1", ext_valid);
        end
        @(posedge clk); #2 rst = 1'b1; #1;
        vectors++;
        if (ext_valid !== 1'b0 || capture_busy !== 1'b0) begin
            miscompares++; $display("FAIL rh_reset: valid=%b busy=%b expected 0/0", ext_valid, capture_busy);
        end
        @(negedge clk); rst = 1'b0;
        repeat (6) @(negedge clk);
        capture_req = 1'b1; @(negedge clk); capture_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (ext_valid !== 1'b1 || ext_count !== 10'h001 || act_bus !== exp_bus) begin
            miscompares++; $display("FAIL rh_recapture: valid=%b count=%h expected 1/001", ext_valid, ext_count);
        end
        ext_ready = 1'b1; @(negedge clk); ext_ready = 1'b0;
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                cnt_in = ($urandom_range(0, 4) == 0) ? CNT_W'($urandom) : cnt_in + 2'd1;
                hold   = $urandom_range(1, 8);
            end
            hold--;
            capture_req = ($urandom_range(0, 9) == 0);
            ext_ready   = ($urandom_range(0, 2) == 0);
            clear       = ($urandom_range(0, 40) == 0);
            @(negedge clk);
            vectors++;
            if (act_bus !== exp_bus) begin
                miscompares++; $display("FAIL random c%0d: got %h expected %h", c, act_bus, exp_bus);
            end
        end
        capture_req = 1'b0; ext_ready = 1'b0; clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cnt_in = '0; clear = 1'b0; capture_req = 1'b0; ext_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_count();
        test_glitch();
        test_overflow();
        test_clear_on_wrap();
        test_handshake();
        test_reset_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
